// File: rtl/imm_gen_pipe.sv
// RV32I/RV64I immediate decoder with a registered valid/ready output and a one-entry skid; 1-cycle latency.
// in_ready comes from a flop only, so stalls never create a combinational path back upstream.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   input  logic [2:0]       imm_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm_data,
   output logic             imm_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            illegal;
   } beat_t;

   beat_t            dec_beat;
   beat_t            out_d, out_q;
   beat_t            skid_d, skid_q;
   logic             out_vld_d, out_vld_q;
   logic             skid_vld_d, skid_vld_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             fire_in;
   logic             out_free;
   logic             unused_opcode;

   // Opcode bits never select immediate content.
   assign unused_opcode = ^instruction[6:0];

   always_comb begin
      dec_beat = '0;
      unique case (imm_src)
         3'b000: dec_beat.data = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
         3'b001: dec_beat.data = {{(XLEN-12){instruction[31]}}, instruction[31:25],
                                  instruction[11:7]};
         3'b010: dec_beat.data = {{(XLEN-12){instruction[31]}}, instruction[7],
                                  instruction[30:25], instruction[11:8], 1'b0};
         3'b011: dec_beat.data = {{(XLEN-31){instruction[31]}}, instruction[30:12], 12'b0};
         3'b100: dec_beat.data = {{(XLEN-20){instruction[31]}}, instruction[19:12],
                                  instruction[20], instruction[30:21], 1'b0};
         3'b101: dec_beat.data = {{(XLEN-6){1'b0}}, (XLEN == 64) & instruction[25],
                                  instruction[24:20]};
         3'b110: dec_beat.data = {{(XLEN-5){1'b0}}, instruction[19:15]};
         default: dec_beat.illegal = 1'b1;
      endcase
   end

   assign in_ready = ~skid_vld_q;
   assign fire_in  = in_valid & ~skid_vld_q;
   assign out_free = ~out_vld_q | out_ready;

   // The skid only fills while the output is stalled, so it drains first once the output frees.
   always_comb begin
      out_d      = out_q;
      out_vld_d  = out_vld_q;
      skid_d     = skid_q;
      skid_vld_d = skid_vld_q;
      if (out_free) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = 1'b0;
         end else if (fire_in) begin
            out_d     = dec_beat;
            out_vld_d = 1'b1;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (fire_in) begin
         skid_d     = dec_beat;
         skid_vld_d = 1'b1;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (fire_in && dec_beat.illegal && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q      <= '0;
         out_vld_q  <= 1'b0;
         skid_q     <= '0;
         skid_vld_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
         skid_q     <= skid_d;
         skid_vld_q <= skid_vld_d;
         cnt_q      <= cnt_d;
      end
   end

   assign out_valid   = out_vld_q;
   assign imm_data    = out_q.data;
   assign imm_illegal = out_q.illegal;
   assign illegal_cnt = cnt_q;

endmodule
